// File: rtl/ni_dma_scheduler.sv
// ni_dma_scheduler
//   Shares one NI DMA engine between NREQ requesters. A round-robin arbiter
//   picks a requester, then the block runs the NI command sequence on its own
//   wishbone master port:
//     1. write the packet size to NI_BASE_ADDR+3
//     2. write the memory pointer to NI_BASE_ADDR+4 (read) or +5 (write);
//        this write starts the transfer
//     3. wait POLL_GAP cycles, read status at NI_BASE_ADDR+0, and repeat
//        until bit 0 (NI busy) reads back as 0
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_i[NREQ]                 level request, held until done_o/err_o
//   rd_i[NREQ]                  1 = NI read command, 0 = NI write command
//   pck_size_i[NREQ*PCKw]       packet size, requester i at [i*PCKw +: PCKw]
//   mem_ptr_i[NREQ*Dw]          byte memory pointer, requester i at [i*Dw +: Dw]
//   grant_o[NREQ]               one-hot, requester being served
//   done_o / err_o[NREQ]        one-cycle completion / bus-error pulse
//   busy_o                      high while a command sequence is in flight
//   m_*_o / m_*_i               wishbone master towards the NI slave port
module ni_dma_scheduler #(
  parameter int          NREQ         = 4,
  parameter logic [31:0] NI_BASE_ADDR = 32'h0,
  parameter int          Dw           = 32,
  parameter int          M_Aw         = 32,
  parameter int          TAGw         = 3,
  parameter int          SELw         = 4,
  parameter int          PCKw         = 10,
  parameter int          POLL_GAP     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      rd_i,
  input  logic [NREQ*PCKw-1:0] pck_size_i,
  input  logic [NREQ*Dw-1:0]   mem_ptr_i,
  output logic [NREQ-1:0]      grant_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic                 busy_o,
  output logic [SELw-1:0]      m_sel_o,
  output logic [Dw-1:0]        m_dat_o,
  output logic [M_Aw-1:0]      m_addr_o,
  output logic [TAGw-1:0]      m_tag_o,
  output logic                 m_stb_o,
  output logic                 m_cyc_o,
  output logic                 m_we_o,
  input  logic [Dw-1:0]        m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 m_err_i,
  input  logic                 m_rty_i
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [M_Aw-1:0] BASE     = M_Aw'(NI_BASE_ADDR);
  localparam logic [7:0]      GAP_LAST = 8'(POLL_GAP - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    WR_SIZE = 5'b00010,
    WR_PTR  = 5'b00100,
    GAP     = 5'b01000,
    POLL    = 5'b10000
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     rr_q;      // search start for the next arbitration
  logic [IW-1:0]     g_q;       // index of the granted requester
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;
  logic [NREQ-1:0]   err_q;
  logic              rd_q;
  logic [PCKw-1:0]   pck_q;
  logic [Dw-1:0]     ptr_q;
  logic [7:0]        cnt_q;     // GAP cycle counter
  logic              rty_q;     // one-cycle strobe drop after a retry

  // Per-requester views of the flattened command inputs.
  logic [PCKw-1:0] pck_a [NREQ];
  logic [Dw-1:0]   ptr_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign pck_a[gi] = pck_size_i[gi*PCKw +: PCKw];
    assign ptr_a[gi] = mem_ptr_i[gi*Dw +: Dw];
  end

  // Round-robin pick: first set request at or above rr_q, wrapping.
  logic [IW-1:0] sel_d;
  logic          any_d;
  int            idx;

  always_comb begin
    sel_d = '0;
    any_d = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!any_d && req_i[IW'(idx)]) begin
        sel_d = IW'(idx);
        any_d = 1'b1;
      end
    end
  end

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    rr_next = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
  endfunction

  // A bus access is live in the three bus states, except during the single
  // cycle that follows a retry.
  logic bus_st;
  logic bus_act;

  assign bus_st  = (state_q == WR_SIZE) || (state_q == WR_PTR) || (state_q == POLL);
  assign bus_act = bus_st && !rty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
      pck_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rty_q   <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      rty_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            g_q     <= sel_d;
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << sel_d;
            rd_q    <= rd_i[sel_d];
            pck_q   <= pck_a[sel_d];
            ptr_q   <= ptr_a[sel_d];
            state_q <= WR_SIZE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) state_q <= POLL;
          else                   cnt_q   <= cnt_q + 8'd1;
        end
        WR_SIZE, WR_PTR, POLL: begin
          if (bus_act) begin
            // err beats rty beats ack when several arrive together
            if (m_err_i) begin
              err_q   <= grant_q;
              grant_q <= '0;
              rr_q    <= rr_next(g_q);
              state_q <= IDLE;
            end else if (m_rty_i) begin
              rty_q <= 1'b1;
            end else if (m_ack_i) begin
              case (state_q)
                WR_SIZE: state_q <= WR_PTR;
                WR_PTR: begin
                  cnt_q   <= '0;
                  state_q <= GAP;
                end
                default: begin
                  if (m_dat_i[0]) begin
                    cnt_q   <= '0;
                    state_q <= GAP;
                  end else begin
                    done_q  <= grant_q;
                    grant_q <= '0;
                    rr_q    <= rr_next(g_q);
                    state_q <= IDLE;
                  end
                end
              endcase
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus address/data follow the state; idle states park on the base address.
  always_comb begin
    m_addr_o = BASE;
    m_dat_o  = '0;
    case (state_q)
      WR_SIZE: begin
        m_addr_o = BASE + M_Aw'(3);
        m_dat_o  = Dw'(pck_q);
      end
      WR_PTR: begin
        m_addr_o = rd_q ? BASE + M_Aw'(4) : BASE + M_Aw'(5);
        m_dat_o  = ptr_q;
      end
      default: ;
    endcase
  end

  assign m_stb_o = bus_act;
  assign m_cyc_o = bus_act;
  assign m_we_o  = bus_act && ((state_q == WR_SIZE) || (state_q == WR_PTR));
  assign m_sel_o = '1;
  assign m_tag_o = '0;

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != IDLE);

  // Only the busy bit of the status word is meaningful.
  logic unused_dat;
  assign unused_dat = ^m_dat_i[Dw-1:1];

endmodule

// File: doc/ni_dma_scheduler.md
Name: ni_dma_scheduler

Overview:
- Shares one network-interface (NI) DMA engine between NREQ requesters: JTAG loader, CPU-side host ports, and similar.
- Round-robin arbitration picks one requester. The block then runs the NI command sequence on its own wishbone master port: write packet size, write memory pointer (this starts the send or receive), then poll NI status until not busy.
- Sits between requester ports and the NI slave port, in place of per-requester NI command FSMs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NI_BASE_ADDR, 32'h0, word address of the NI register block.
- Dw, 32, wishbone data width.
- M_Aw, 32, wishbone master address width.
- TAGw, 3, wishbone tag width.
- SELw, 4, wishbone byte-select width.
- PCKw, 10, packet-size field width (PCKw <= Dw).
- POLL_GAP, 8, idle cycles between status polls (1..255).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset; one clock only.
- req_i, in, NREQ, level request per requester; held until done_o or err_o.
- rd_i, in, NREQ, 1 = NI read command, 0 = NI write command.
- pck_size_i, in, NREQ*PCKw, packet size per requester; requester i uses bits [i*PCKw +: PCKw].
- mem_ptr_i, in, NREQ*Dw, byte memory pointer per requester; slice [i*Dw +: Dw].
- grant_o, in/out: out, NREQ, one-hot; requester being served.
- done_o, out, NREQ, one-cycle completion pulse.
- err_o, out, NREQ, one-cycle bus-error pulse.
- busy_o, out, 1, high whenever state != IDLE.
- m_sel_o, m_dat_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o, out, SELw/Dw/M_Aw/TAGw/1/1/1, wishbone master.
- m_dat_i, m_ack_i, m_err_i, m_rty_i, in, Dw/1/1/1, wishbone master responses.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Values after reset: state IDLE, rr pointer = 0, grant_o = 0, done_o = 0, err_o = 0, busy_o = 0, m_stb_o = m_cyc_o = m_we_o = 0, m_addr_o = NI_BASE_ADDR, m_dat_o = 0, m_sel_o = all ones, m_tag_o = 0.
- Reset mid-operation aborts the sequence. No done_o or err_o pulse is issued for the aborted request.
- States (one-hot): IDLE, WR_SIZE, WR_PTR, GAP, POLL.
- IDLE:
  - If any req_i bit is set, grant the first set bit searching from the rr pointer upward, with wrap.
  - Register grant_o, the granted rd, pck_size and mem_ptr.
  - Next state is WR_SIZE; the first bus cycle starts the cycle after the grant.
  - Later changes on the inputs are ignored until the request completes.
- WR_SIZE:
  - stb/cyc/we = 1, addr = NI_BASE_ADDR+3, dat = zero-extended pck_size.
  - On ack, go to WR_PTR.
- WR_PTR:
  - stb/cyc/we = 1, dat = mem_ptr.
  - addr = NI_BASE_ADDR+4 if rd = 1, otherwise NI_BASE_ADDR+5.
  - On ack, go to GAP.
- GAP:
  - No bus activity. A counter runs for POLL_GAP cycles, then the state goes to POLL.
  - The counter clears on entry to GAP.
- POLL:
  - stb/cyc = 1, we = 0, addr = NI_BASE_ADDR+0.
  - On ack with m_dat_i[0] = 1 (NI busy), go to GAP.
  - On ack with m_dat_i[0] = 0, pulse done_o[g] in the next cycle, clear grant_o, and go to IDLE.
- Bus control: m_stb_o and m_cyc_o are combinational from state and deassert in the cycle after the ack. Only one outstanding access at a time.
- m_err_i in any bus state:
  - err_o[g] pulses in the next cycle, grant_o clears, state goes to IDLE.
  - The remaining steps are skipped.
- m_rty_i:
  - stb/cyc drop for exactly one cycle, then the same access is reissued.
  - The state and address do not change.
- Simultaneous ack+err/rty: err has priority over rty, and rty has priority over ack.
- Round robin: the rr pointer updates to (g+1) mod NREQ when the request finishes, either done or err. Starvation bound: a waiting requester is served within NREQ-1 other grants.
- Back-to-back requests: at least one IDLE cycle between requests, and done_o is visible in that IDLE cycle. A requester that keeps req_i high after done_o is treated as a new request.
- Requester drop: if req_i[g] drops while granted, the sequence still completes and done_o still pulses.
- Status register: busy bit is bit 0 of the NI status register.

Test Plan:
- Single write request: req_i = 0001, pck_size = 5, mem_ptr = 0x400, NI_BASE_ADDR = 0x100, ack every access, status 0 on first poll.
  - Writes 0x103 <= 5 and 0x105 <= 0x400.
  - 8 idle cycles, then one read of 0x100.
  - done_o = 0001 for one cycle; busy_o low afterwards.
- Read command: rd_i[2] = 1, req_i = 0100 -> the pointer write goes to 0x104 and grant_o = 0100.
- Busy polling: status returns bit0 = 1 twice, then 0 -> exactly 3 status reads, each separated by POLL_GAP idle cycles; a single done_o pulse.
- Round robin: req_i = 1111 held, pointer 0 -> grant order 0,1,2,3,0. After req_i = 1010 with pointer = 2 -> requester 3 is granted first, then 1.
- Errors and retries:
  - m_err_i on the WR_PTR access -> err_o[g] pulse, no poll, IDLE, pointer advanced.
  - m_rty_i on WR_SIZE -> stb low one cycle, then the same address and data are reissued.
- Reset mid-operation: assert reset for 1 cycle during GAP -> all outputs at reset values the next cycle, no done_o pulse, the next grant goes to requester 0.
